riscv_immgen_pipe: RTL and testbench
====================================

RISCV_IMMGEN_PIPE -- requirements
Module: riscv_immgen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the immediate width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter B_SHIFT, default 1, where 1 means B/J immediates carry implicit bit0=0 (byte offset) and 0 means the raw 12/20-bit field sign-extended (halfword count).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the illegal-instruction counter width.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 valid_i  input  1  instruction_i holds a valid instruction.
REQ-007 ready_o  output  1  block can accept; registered, no combinational path from ready_i.
REQ-008 instruction_i  input  32  instruction word.
REQ-009 valid_o  output  1  immediate_o/fmt_o/illegal_o valid.
REQ-010 ready_i  input  1  downstream accepts this cycle.
REQ-011 immediate_o  output  XLEN  sign-/zero-extended immediate.
REQ-012 fmt_o  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
REQ-013 illegal_o  output  1  opcode not decodable.
REQ-014 illegal_cnt_o  output  CNT_W  saturating count of illegal instructions delivered.

Function
REQ-015 The block SHALL decode as: 0010011, 0000011, 1100111 -> I; 0011011 -> I if XLEN=64, else ILLEGAL; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011, 0111011 (latter XLEN=64 only) -> R; all else -> ILLEGAL.
REQ-016 I SHALL yield sign-extended inst[31:20], except opcode 0010011 with funct3 001/101, which SHALL yield zero-extended shamt: inst[25:20] if XLEN=64, inst[24:20] if XLEN=32.
REQ-017 S SHALL yield sign-extended {inst[31:25],inst[11:7]}.
REQ-018 B SHALL yield sign-extended {inst[31],inst[7],inst[30:25],inst[11:8]}, with 1'b0 appended when B_SHIFT=1.
REQ-019 U SHALL yield {inst[31:12],12'b0} sign-extended from bit 31.
REQ-020 J SHALL yield sign-extended {inst[31],inst[19:12],inst[20],inst[30:21]}, with 1'b0 appended when B_SHIFT=1.
REQ-021 R and ILLEGAL SHALL yield immediate 0; illegal_o=1 only for ILLEGAL.
REQ-022 Latency SHALL be 1 cycle: an instruction accepted (valid_i&&ready_o) at edge N appears on valid_o after edge N when the output stage is free.
REQ-023 Storage SHALL be a 2-entry skid: output register (OUT) plus one skid register (SKID); ready_o SHALL equal !SKID.valid registered.
REQ-024 On accept with OUT empty or ready_i=1 and SKID empty, the new result SHALL load OUT.
REQ-025 On accept with OUT valid and ready_i=0, the result SHALL load SKID and ready_o SHALL drop next cycle.
REQ-026 When OUT valid, ready_i=1 and SKID valid, OUT SHALL load SKID, SKID SHALL clear and ready_o SHALL rise next cycle; no input is accepted that cycle.
REQ-027 When OUT valid, ready_i=1, SKID empty and no accept, valid_o SHALL fall next cycle.
REQ-028 Outputs SHALL hold stable while valid_o=1 and ready_i=0; order SHALL be preserved; no loss or duplication.
REQ-029 illegal_cnt_o SHALL increment on each handshake (valid_o&&ready_i) with illegal_o=1 and SHALL saturate at all-ones.
REQ-030 Throughput SHALL be one instruction per cycle while ready_i=1.

Reset
REQ-031 While rst_ni=0: valid_o=0, ready_o=1, immediate_o=0, fmt_o=0, illegal_o=0, illegal_cnt_o=0, both entries invalid.
REQ-032 Reset asserted mid-transfer SHALL discard OUT and SKID contents immediately; first accept is allowed on the first rising edge after deassertion.

Verification
REQ-033 XLEN=64: 0xFFF00093 (addi -1) -> immediate_o=0xFFFFFFFFFFFFFFFF, fmt_o=1, one cycle after accept.
REQ-034 0xFE21BC23 (sd -8) -> 0xFFFFFFFFFFFFFFF8, fmt_o=2; 0x123452B7 (lui) -> 0x0000000012345000, fmt_o=4.
REQ-035 0xFE000EE3 (beq -4) -> 0xFFFFFFFFFFFFFFFC with B_SHIFT=1; 0xFFFFFFFFFFFFFFFE with B_SHIFT=0; fmt_o=3.
REQ-036 Back-to-back A,B,C with ready_i=0 for 3 cycles -> A held on outputs, B in SKID, ready_o=0; release -> A,B,C delivered in order, none lost.
REQ-037 CNT_W=2, four 0x0000007F handshakes -> illegal_o=1, fmt_o=7, immediate_o=0, counter 1,2,3,3 (saturates).
REQ-038 rst_ni low with OUT and SKID full -> valid_o=0, ready_o=1 immediately, counter=0.

Source files
------------

// File: rtl/riscv_immgen_pipe.sv
// -----------------------------------------------------------------------------
// riscv_immgen_pipe
//
// Decodes the immediate field of a RISC-V instruction word and delivers it
// through a two-entry skid buffer. The buffer gives one-cycle latency and full
// throughput, and ready_o never depends combinationally on ready_i.
//
// Parameters
//   XLEN    : immediate width, 32 or 64
//   B_SHIFT : 1 -> B/J immediates are byte offsets (implicit bit0 = 0)
//             0 -> B/J immediates are the raw field sign-extended
//   CNT_W   : width of the saturating illegal-instruction counter
//
// Ports
//   clk_i          : clock, all state changes on rising edge
//   rst_ni         : asynchronous active-low reset
//   valid_i        : instruction_i holds a valid instruction
//   ready_o        : block can accept an instruction (registered)
//   instruction_i  : 32-bit instruction word
//   valid_o        : immediate_o / fmt_o / illegal_o are valid
//   ready_i        : downstream accepts this cycle
//   immediate_o    : sign-/zero-extended immediate
//   fmt_o          : R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7
//   illegal_o      : opcode not decodable
//   illegal_cnt_o  : saturating count of illegal instructions delivered
// -----------------------------------------------------------------------------
module riscv_immgen_pipe #(
    parameter int XLEN    = 64,
    parameter int B_SHIFT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instruction_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  immediate_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    localparam bit IS_RV64 = (XLEN == 64);

    // One decoded result as it travels through the two storage entries.
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } result_t;

    // -------------------------------------------------------------------------
    // Immediate candidates, all built at 64 bits and truncated to XLEN at the
    // end. Sign-extending to 64 then slicing gives the right XLEN=32 result
    // without zero-width replications.
    // -------------------------------------------------------------------------
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    assign inst   = instruction_i;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    logic [63:0] imm_i_w;
    logic [63:0] imm_s_w;
    logic [63:0] imm_u_w;
    logic [63:0] imm_b_w;
    logic [63:0] imm_j_w;
    logic [63:0] shamt_w;

    assign imm_i_w = {{52{inst[31]}}, inst[31:20]};
    assign imm_s_w = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u_w = {{32{inst[31]}}, inst[31:12], 12'b0};

    // Shift amounts are unsigned; the funct7 bits above them (e.g. the
    // arithmetic-shift flag in bit 30) must not leak into the immediate.
    generate
        if (IS_RV64) begin : g_shamt64
            assign shamt_w = {58'b0, inst[25:20]};
        end else begin : g_shamt32
            assign shamt_w = {59'b0, inst[24:20]};
        end
    endgenerate

    // Branch and jump offsets: either byte offsets (extra zero LSB) or raw
    // halfword counts, selected at elaboration time.
    logic [11:0] b_field;
    logic [19:0] j_field;

    assign b_field = {inst[31], inst[7], inst[30:25], inst[11:8]};
    assign j_field = {inst[31], inst[19:12], inst[20], inst[30:21]};

    generate
        if (B_SHIFT != 0) begin : g_bj_bytes
            assign imm_b_w = {{51{inst[31]}}, b_field, 1'b0};
            assign imm_j_w = {{43{inst[31]}}, j_field, 1'b0};
        end else begin : g_bj_halfwords
            assign imm_b_w = {{52{inst[31]}}, b_field};
            assign imm_j_w = {{44{inst[31]}}, j_field};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Format decode
    // -------------------------------------------------------------------------
    logic [63:0] dec_imm_w;
    result_t     dec_result;

    always_comb begin
        dec_imm_w      = 64'd0;
        dec_result.fmt = FMT_ILL;
        dec_result.ill = 1'b1;
        unique case (opcode)
            OP_IMM: begin
                dec_result.fmt = FMT_I;
                dec_result.ill = 1'b0;
                // slli / srli / srai carry a shift amount, not a signed value
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_imm_w = shamt_w;
                end else begin
                    dec_imm_w = imm_i_w;
                end
            end
            OP_LOAD, OP_JALR: begin
                dec_result.fmt = FMT_I;
                dec_result.ill = 1'b0;
                dec_imm_w      = imm_i_w;
            end
            OP_IMM32: begin
                if (IS_RV64) begin
                    dec_result.fmt = FMT_I;
                    dec_result.ill = 1'b0;
                    dec_imm_w      = imm_i_w;
                end
            end
            OP_STORE: begin
                dec_result.fmt = FMT_S;
                dec_result.ill = 1'b0;
                dec_imm_w      = imm_s_w;
            end
            OP_BRANCH: begin
                dec_result.fmt = FMT_B;
                dec_result.ill = 1'b0;
                dec_imm_w      = imm_b_w;
            end
            OP_LUI, OP_AUIPC: begin
                dec_result.fmt = FMT_U;
                dec_result.ill = 1'b0;
                dec_imm_w      = imm_u_w;
            end
            OP_JAL: begin
                dec_result.fmt = FMT_J;
                dec_result.ill = 1'b0;
                dec_imm_w      = imm_j_w;
            end
            OP_REG: begin
                dec_result.fmt = FMT_R;
                dec_result.ill = 1'b0;
            end
            OP_REG32: begin
                if (IS_RV64) begin
                    dec_result.fmt = FMT_R;
                    dec_result.ill = 1'b0;
                end
            end
            default: begin
                dec_result.fmt = FMT_ILL;
                dec_result.ill = 1'b1;
            end
        endcase
        dec_result.imm = dec_imm_w[XLEN-1:0];
    end

    // -------------------------------------------------------------------------
    // Two-entry skid buffer
    //   OUT  drives the outputs.
    //   SKID catches the one result accepted while OUT is stalled; while it
    //   is occupied ready_o is low, so at most one extra entry is needed.
    //   Invariant: SKID valid implies OUT valid.
    // -------------------------------------------------------------------------
    logic    out_valid_reg,  out_valid_next;
    result_t out_data_reg,   out_data_next;
    logic    skid_valid_reg, skid_valid_next;
    result_t skid_data_reg,  skid_data_next;
    logic    accept;

    assign ready_o = !skid_valid_reg;
    assign accept  = valid_i && ready_o;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;

        if (skid_valid_reg) begin
            // ready_o is low, so nothing is accepted; drain SKID into OUT.
            if (ready_i) begin
                out_data_next   = skid_data_reg;
                skid_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_reg || ready_i) begin
                out_valid_next = 1'b1;
                out_data_next  = dec_result;
            end else begin
                skid_valid_next = 1'b1;
                skid_data_next  = dec_result;
            end
        end else if (ready_i) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
        end
    end

    // -------------------------------------------------------------------------
    // Illegal-instruction counter: counts delivered (handshaken) illegal
    // results, not accepted ones, and sticks at all-ones.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] illegal_cnt_reg, illegal_cnt_next;

    always_comb begin
        illegal_cnt_next = illegal_cnt_reg;
        if (out_valid_reg && ready_i && out_data_reg.ill && (illegal_cnt_reg != '1)) begin
            illegal_cnt_next = illegal_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_cnt_reg <= '0;
        end else begin
            illegal_cnt_reg <= illegal_cnt_next;
        end
    end

    assign valid_o       = out_valid_reg;
    assign immediate_o   = out_data_reg.imm;
    assign fmt_o         = out_data_reg.fmt;
    assign illegal_o     = out_data_reg.ill;
    assign illegal_cnt_o = illegal_cnt_reg;

endmodule

// File: tb/tb_riscv_immgen_pipe.sv
// -----------------------------------------------------------------------------
// tb_riscv_immgen_pipe
//
// Directed test of riscv_immgen_pipe. Three instances share the same stimulus:
//   u_dut    : XLEN=64, B_SHIFT=1, CNT_W=2 (main checks, counter saturation)
//   u_dut_b0 : XLEN=64, B_SHIFT=0          (halfword B/J offsets)
//   u_dut32  : XLEN=32                      (RV32 shamt / W-opcode handling)
// Inputs are driven on the falling edge, outputs sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_riscv_immgen_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [31:0] instruction_i = 32'h0;

    logic        ready_o, valid_o, illegal_o;
    logic [63:0] immediate_o;
    logic [2:0]  fmt_o;
    logic [1:0]  illegal_cnt_o;

    logic        b0_ready_o, b0_valid_o, b0_illegal_o;
    logic [63:0] b0_immediate_o;
    logic [2:0]  b0_fmt_o;
    logic [15:0] b0_illegal_cnt_o;

    logic        r32_ready_o, r32_valid_o, r32_illegal_o;
    logic [31:0] r32_immediate_o;
    logic [2:0]  r32_fmt_o;
    logic [15:0] r32_illegal_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    riscv_immgen_pipe #(.XLEN(64), .B_SHIFT(1), .CNT_W(2)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .instruction_i(instruction_i), .valid_o(valid_o), .ready_i(ready_i),
        .immediate_o(immediate_o), .fmt_o(fmt_o), .illegal_o(illegal_o),
        .illegal_cnt_o(illegal_cnt_o)
    );

    riscv_immgen_pipe #(.XLEN(64), .B_SHIFT(0), .CNT_W(16)) u_dut_b0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(b0_ready_o),
        .instruction_i(instruction_i), .valid_o(b0_valid_o), .ready_i(ready_i),
        .immediate_o(b0_immediate_o), .fmt_o(b0_fmt_o), .illegal_o(b0_illegal_o),
        .illegal_cnt_o(b0_illegal_cnt_o)
    );

    riscv_immgen_pipe #(.XLEN(32), .B_SHIFT(1), .CNT_W(16)) u_dut32 (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(r32_ready_o),
        .instruction_i(instruction_i), .valid_o(r32_valid_o), .ready_i(ready_i),
        .immediate_o(r32_immediate_o), .fmt_o(r32_fmt_o), .illegal_o(r32_illegal_o),
        .illegal_cnt_o(r32_illegal_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    // Hand-computed expectations for each vector.
    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic [63:0] imm_b0;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1}; // addi -1
        vecs[1]  = '{32'hFE21BC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd2}; // sd -8
        vecs[2]  = '{32'h123452B7, 64'h0000_0000_1234_5000, 3'd4, 64'h0000_0000_1234_5000, 32'h1234_5000, 3'd4}; // lui
        vecs[3]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFC, 3'd3}; // beq -4
        vecs[4]  = '{32'hFF9FF0EF, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFF8, 3'd5}; // jal -8
        vecs[5]  = '{32'h03F09093, 64'd63,                  3'd1, 64'd63,                  32'd31,         3'd1}; // slli 63
        vecs[6]  = '{32'h43F0D093, 64'd63,                  3'd1, 64'd63,                  32'd31,         3'd1}; // srai 63
        vecs[7]  = '{32'h80000017, 64'hFFFF_FFFF_8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4}; // auipc
        vecs[8]  = '{32'h002081B3, 64'd0,                   3'd0, 64'd0,                   32'd0,          3'd0}; // add
        vecs[9]  = '{32'hFFF0809B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0,          3'd7}; // addiw -1
        vecs[10] = '{32'h002081BB, 64'd0,                   3'd0, 64'd0,                   32'd0,          3'd7}; // addw
        vecs[11] = '{32'h7FF02083, 64'h7FF,                 3'd1, 64'h7FF,                 32'h7FF,        3'd1}; // lw 2047
    end

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk("rst_valid_o",   {63'd0, valid_o},       64'd0);
        chk("rst_ready_o",   {63'd0, ready_o},       64'd1);
        chk("rst_imm",       immediate_o,            64'd0);
        chk("rst_fmt",       {61'd0, fmt_o},         64'd0);
        chk("rst_illegal",   {63'd0, illegal_o},     64'd0);
        chk("rst_cnt",       {62'd0, illegal_cnt_o}, 64'd0);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        ready_i = 1'b1;

        // ---------------- illegal stream, counter saturation ----------------
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            valid_i       = 1'b1;
            instruction_i = 32'h0000007F;
            @(posedge clk_i);
            #1;
            chk("ill_valid", {63'd0, valid_o},   64'd1);
            chk("ill_flag",  {63'd0, illegal_o}, 64'd1);
            chk("ill_fmt",   {61'd0, fmt_o},     64'd7);
            chk("ill_imm",   immediate_o,        64'd0);
            // the previous illegal result was handshaken at this same edge
            chk("ill_cnt",   {62'd0, illegal_cnt_o}, 64'(k));
            $display("xfer illegal #%0d cnt=%0d", k, illegal_cnt_o);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("ill_cnt_sat", {62'd0, illegal_cnt_o}, 64'd3);
        chk("ill_drained", {63'd0, valid_o},       64'd0);

        // ---------------- back-to-back vectors, ready_i held high ----------------
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            valid_i       = 1'b1;
            instruction_i = vecs[i].instr;
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_valid", i),  {63'd0, valid_o},  64'd1);
            chk($sformatf("v%0d_ready", i),  {63'd0, ready_o},  64'd1);
            chk($sformatf("v%0d_imm", i),    immediate_o,       vecs[i].imm64);
            chk($sformatf("v%0d_fmt", i),    {61'd0, fmt_o},    {61'd0, vecs[i].fmt64});
            chk($sformatf("v%0d_ill", i),    {63'd0, illegal_o}, 64'(vecs[i].fmt64 == 3'd7));
            chk($sformatf("v%0d_imm_b0", i), b0_immediate_o,    vecs[i].imm_b0);
            chk($sformatf("v%0d_imm32", i),  {32'd0, r32_immediate_o}, {32'd0, vecs[i].imm32});
            chk($sformatf("v%0d_fmt32", i),  {61'd0, r32_fmt_o}, {61'd0, vecs[i].fmt32});
            chk($sformatf("v%0d_ill32", i),  {63'd0, r32_illegal_o}, 64'(vecs[i].fmt32 == 3'd7));
            $display("xfer v%0d instr=%h imm=%h fmt=%0d imm_b0=%h imm32=%h fmt32=%0d",
                     i, vecs[i].instr, immediate_o, fmt_o, b0_immediate_o, r32_immediate_o, r32_fmt_o);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("stream_drained", {63'd0, valid_o}, 64'd0);

        // ---------------- skid: A,B,C with ready_i low for 3 cycles ----------------
        @(negedge clk_i);
        ready_i       = 1'b0;
        valid_i       = 1'b1;
        instruction_i = 32'h00100093;          // A: addi 1
        @(posedge clk_i);
        #1;
        chk("skid_a_out", immediate_o, 64'd1);
        @(negedge clk_i);
        instruction_i = 32'h00200093;          // B: addi 2 -> lands in SKID
        @(posedge clk_i);
        #1;
        chk("skid_a_hold1", immediate_o,       64'd1);
        chk("skid_full",    {63'd0, ready_o},  64'd0);
        @(negedge clk_i);
        instruction_i = 32'h00300093;          // C: must wait
        @(posedge clk_i);
        #1;
        chk("skid_a_hold2", immediate_o,       64'd1);
        chk("skid_valid",   {63'd0, valid_o},  64'd1);
        chk("skid_full2",   {63'd0, ready_o},  64'd0);
        $display("xfer skid stall imm=%h ready_o=%0d", immediate_o, ready_o);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("skid_b_out",   immediate_o,       64'd2);
        chk("skid_ready",   {63'd0, ready_o},  64'd1);
        $display("xfer skid release imm=%h", immediate_o);
        @(posedge clk_i);
        #1;
        chk("skid_c_out",   immediate_o,       64'd3);
        chk("skid_c_valid", {63'd0, valid_o},  64'd1);
        $display("xfer skid c imm=%h", immediate_o);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("skid_drained", {63'd0, valid_o},  64'd0);

        // ---------------- reset with both entries full ----------------
        @(negedge clk_i);
        ready_i       = 1'b0;
        valid_i       = 1'b1;
        instruction_i = 32'h0000007F;
        @(posedge clk_i);
        @(negedge clk_i);
        instruction_i = 32'h00100093;
        @(posedge clk_i);
        #1;
        chk("pre_rst_full", {63'd0, ready_o}, 64'd0);
        @(negedge clk_i);
        valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, valid_o},       64'd0);
        chk("mid_rst_ready", {63'd0, ready_o},       64'd1);
        chk("mid_rst_cnt",   {62'd0, illegal_cnt_o}, 64'd0);
        chk("mid_rst_imm",   immediate_o,            64'd0);
        $display("xfer mid-reset valid_o=%0d ready_o=%0d", valid_o, ready_o);
        @(negedge clk_i);
        rst_ni        = 1'b1;
        valid_i       = 1'b1;
        instruction_i = 32'h123452B7;
        @(posedge clk_i);
        #1;
        chk("post_rst_valid", {63'd0, valid_o}, 64'd1);
        chk("post_rst_imm",   immediate_o,      64'h12345000);
        chk("post_rst_fmt",   {61'd0, fmt_o},   64'd4);
        $display("xfer post-reset imm=%h", immediate_o);
        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_drain", {63'd0, valid_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
